data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Responder end of the data-memory load/store interface. It accepts one load or store request at a time from the memory stage and holds a local word-organised RAM with byte-lane writes. After a fixed latency it returns read data LSB-aligned to the addressed byte, so the requester only sign- or zero-extends. It replaces the behavioural DPI memory with synthesizable RTL behind a valid/ready handshake.

Parameters:
ADDR_W, 32, request address width
DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of two)
BASE_ADDR, 32'h8000_0000, byte address mapped to word 0
LATENCY, 1, cycles from request accept to resp_valid; legal range 1..15

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0])
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved
resp_valid  output  1  response present
resp_ready  input  1  requester takes the response
resp_rdata  output  32  load data shifted right by the byte offset; 0 for stores and errors
resp_err  output  1  misaligned, out of range, or reserved size

Behaviour:
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. RAM contents are not reset.
- FSM states IDLE, WAIT, RESP. req_ready = (state==IDLE). Only one transaction is outstanding at a time.
- IDLE: on req_valid&&req_ready, latch we/addr/wdata/size and load cnt=LATENCY-1.
  - If LATENCY==1, go directly to RESP.
  - Otherwise go to WAIT.
- WAIT: decrement cnt each cycle; when cnt==1, go to RESP on the next edge.
- Timing: accept at edge t gives resp_valid=1 from edge t+LATENCY.
- Commit edge (the edge entering RESP):
  - Store: RAM write.
  - Load: RAM read registered into resp_rdata.
  - resp_err is registered on the same edge.
- RESP: hold resp_valid, rdata and err stable until resp_ready. On the handshake, clear resp_valid and return to IDLE. A new request is accepted no earlier than the following cycle.
- Decode: off = addr[1:0]; idx = (addr-BASE_ADDR)>>2.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
  - The comparison is unsigned and must not wrap at 2^ADDR_W.
- Error when any of:
  - out of range;
  - size==3;
  - half with off[0]==1;
  - word with off!=0.
- On error: no RAM write, resp_rdata=0, resp_err=1.
- Store lanes:
  - byte: lane off gets wdata[7:0].
  - half: lanes off and off+1 get wdata[15:0].
  - word: all 4 lanes get wdata.
  - Other lanes are unchanged.
- Load: resp_rdata = word >> (8*off). Upper bits above the access size are don't-care for the requester but must equal the shifted word (no masking). Stores return rdata=0, err=0.
- Read-after-write across transactions returns the new data (serial, single outstanding).
- Reset mid-operation: a request in WAIT is dropped with no RAM write and no response. A response in RESP is discarded.
- req_* are ignored outside IDLE. resp_ready is ignored outside RESP.

Decomposition:
- Package mem_resp_pkg:
  - size constants SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2;
  - FSM state enum {IDLE, WAIT, RESP};
  - function size_aligned(size, off).
- Sub-module mem_ram_be: DEPTH_WORDS x 32 synchronous RAM with 4-bit byte-enable write and a registered read on the same port. The responder drives byte enables and an LSB-aligned-to-lane write data replicated across lanes.

Test Plan:
- LATENCY=1: store word 32'hDEADBEEF @8000_0000, then load word @8000_0000 -> resp_valid 1 cycle after each accept; load rdata=DEADBEEF, err=0.
- Store byte 8'h5A @8000_0002, then load word @8000_0000 -> rdata=DE5ABEEF; load byte @8000_0002 -> rdata[7:0]=5A, rdata=0000DE5A.
- Load half @8000_0001 -> err=1, rdata=0. Store word @8000_0006 -> err=1 and a later load @8000_0004 shows unchanged data. Load @7FFF_FFFC and @8000_1000 (DEPTH 1024) -> err=1.
- LATENCY=4, resp_ready held low 3 cycles -> resp_valid asserted exactly 4 cycles after accept; rdata stable while stalled; req_ready=0 until the cycle after the handshake.
- Assert rst during WAIT of a store word 32'h11223344 @8000_0010 -> no response; after reset, load @8000_0010 returns the prior contents. All outputs read 0 and req_ready=1 on the cycle after rst.
- Back-to-back: 16 random aligned stores then loads checked against a reference model -> all match, no err.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the data-memory responder:
// access sizes, FSM states, alignment and byte-lane helpers.
package mem_resp_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Reserved size 3 is never aligned, so it folds into the error decode.
    function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return !off[0];
            SZ_WORD: return off == 2'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate LSB-aligned store data so every candidate lane sees it.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_ram_be.sv
// Single-port word RAM with per-byte write enables and a registered read;
// a write and a read never share an enabled cycle.
module mem_ram_be #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // NOTE: the storage array and its read register carry no reset; contents
    // are undefined until written, and a reset port would block RAM inference.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, fixed request-to-response
// latency, byte-lane RAM, load data returned shifted down to the addressed byte.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
    parameter int unsigned       LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);
    localparam int unsigned     IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] SPAN     = (ADDR_W+1)'(4 * DEPTH_WORDS);
    localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              load_ok_q, load_ok_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [1:0]        cur_size;
    logic [ADDR_W:0]   rel;
    logic              cur_err;
    logic              commit;
    logic              ram_en;
    logic [31:0]       ram_rdata;

    // With LATENCY==1 the commit edge is the accept edge, so IDLE decodes the live request.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_size  = req_size;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_size  = size_q;
        end
        // One extra bit keeps addresses below BASE_ADDR from wrapping into range.
        rel     = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
        cur_err = (rel >= SPAN) || !size_aligned(cur_size, cur_addr[1:0]);
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        load_ok_d = load_ok_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    cnt_d   = CNT_INIT;
                    if (LATENCY == 1) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d   = IDLE;
                    err_d     = 1'b0;
                    load_ok_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d     = cur_err;
            load_ok_d = !cur_we && !cur_err;
        end
    end

    assign ram_en = commit && !cur_err && !rst;

    mem_ram_be #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (cur_we),
        .be   (byte_enables(cur_size, cur_addr[1:0])),
        .idx  (rel[IDX_W+1:2]),
        .wdata(lane_data(cur_size, cur_wdata)),
        .rdata(ram_rdata)
    );

    // NOTE: flops use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            load_ok_q <= load_ok_d;
        end
    end

    // Payload is only consumed after IDLE has latched it, so it needs no reset.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        size_q  <= size_d;
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = err_q;
    assign resp_rdata = load_ok_q ? (ram_rdata >> {addr_q[1:0], 3'b000}) : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=1 and a LATENCY=4 instance checked
// against a byte-addressed reference memory kept in the bench.
module tb_data_mem_responder;
    import mem_resp_pkg::*;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [1:0]  req_size   [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int          lat_of [2] = '{1, 4};
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  ref_bytes [2][4*DEPTH];

    data_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0])
    );

    data_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Error rule in plain byte-address arithmetic on 64-bit values.
    function automatic bit exp_err(input logic [31:0] addr, input logic [1:0] size);
        longint a = longint'(addr);
        longint lo = longint'(BASE);
        longint n;
        if (size == 2'd3) return 1'b1;
        n = longint'(1) << size;
        if (a < lo || a >= lo + 4 * DEPTH) return 1'b1;
        return (a % n) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input int u, input logic [31:0] addr);
        int rel = int'(addr - BASE);
        int wb  = rel - rel % 4;
        logic [31:0] word = {ref_bytes[u][wb+3], ref_bytes[u][wb+2], ref_bytes[u][wb+1], ref_bytes[u][wb]};
        return word >> (8 * (rel % 4));
    endfunction

    task automatic ref_store(input int u, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size);
        int rel = int'(addr - BASE);
        for (int i = 0; i < (1 << size); i++) begin
            ref_bytes[u][rel+i] = wdata[8*i +: 8];
        end
    endtask

    task automatic check_idle_zero(input int u, input string tag);
        check({tag, "/req_ready"},  32'(req_ready[u]),  32'd1);
        check({tag, "/resp_valid"}, 32'(resp_valid[u]), 32'd0);
        check({tag, "/resp_rdata"}, resp_rdata[u],      32'd0);
        check({tag, "/resp_err"},   32'(resp_err[u]),   32'd0);
    endtask

    // One complete transaction with latency, stall-stability and handshake checks.
    task automatic txn(input int u, input string tag, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input int stall);
        bit          e;
        logic [31:0] exp_rdata;
        int          lat;
        e         = exp_err(addr, size);
        exp_rdata = (we || e) ? 32'd0 : ref_load(u, addr);
        check({tag, "/ready_before"}, 32'(req_ready[u]), 32'd1);
        req_valid[u] = 1'b1;
        req_we[u]    = we;
        req_addr[u]  = addr;
        req_wdata[u] = wdata;
        req_size[u]  = size;
        tick();
        req_valid[u] = 1'b0;
        req_addr[u]  = $urandom;
        req_wdata[u] = $urandom;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (resp_valid[u]) begin
                lat = k;
                break;
            end
            check({tag, "/busy_ready"}, 32'(req_ready[u]), 32'd0);
            tick();
        end
        check({tag, "/latency"}, 32'(lat), 32'(lat_of[u]));
        if (lat == 0) return;
        check({tag, "/err"},   32'(resp_err[u]), 32'(e));
        check({tag, "/rdata"}, resp_rdata[u],    exp_rdata);
        for (int s = 0; s < stall; s++) begin
            tick();
            check({tag, "/stall_valid"}, 32'(resp_valid[u]), 32'd1);
            check({tag, "/stall_rdata"}, resp_rdata[u],      exp_rdata);
            check({tag, "/stall_err"},   32'(resp_err[u]),   32'(e));
            check({tag, "/stall_ready"}, 32'(req_ready[u]),  32'd0);
        end
        resp_ready[u] = 1'b1;
        tick();
        resp_ready[u] = 1'b0;
        check({tag, "/post_valid"}, 32'(resp_valid[u]), 32'd0);
        check({tag, "/post_ready"}, 32'(req_ready[u]),  32'd1);
        if (we && !e) ref_store(u, addr, wdata, size);
    endtask

    function automatic logic [31:0] rnd_addr(input logic [1:0] size);
        logic [31:0] off;
        case (size)
            SZ_BYTE: off = 32'($urandom_range(0, 3));
            SZ_HALF: off = 32'(2 * $urandom_range(0, 1));
            default: off = 32'd0;
        endcase
        return BASE + 32'h200 + 32'(4 * $urandom_range(0, 7)) + off;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] sz;
        for (int u = 0; u < 2; u++) begin
            rst[u]        = 1'b1;
            req_valid[u]  = 1'b0;
            req_we[u]     = 1'b0;
            req_addr[u]   = '0;
            req_wdata[u]  = '0;
            req_size[u]   = '0;
            resp_ready[u] = 1'b0;
        end
        tick();
        tick();
        check_idle_zero(0, "rst_l1");
        check_idle_zero(1, "rst_l4");
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();

        // LATENCY=1 directed sequence.
        txn(0, "st_word",   1, BASE,                32'hDEAD_BEEF, SZ_WORD, 0);
        txn(0, "ld_word",   0, BASE,                32'h0,         SZ_WORD, 0);
        check("ld_word_lit", ref_load(0, BASE), 32'hDEAD_BEEF);
        txn(0, "st_byte",   1, BASE + 32'h2,        32'hCAFE_005A, SZ_BYTE, 0);
        txn(0, "ld_word2",  0, BASE,                32'h0,         SZ_WORD, 0);
        check("ld_word2_lit", ref_load(0, BASE), 32'hDE5A_BEEF);
        txn(0, "ld_byte2",  0, BASE + 32'h2,        32'h0,         SZ_BYTE, 1);
        txn(0, "ld_half2",  0, BASE + 32'h2,        32'h0,         SZ_HALF, 0);
        txn(0, "ld_byte3",  0, BASE + 32'h3,        32'h0,         SZ_BYTE, 0);
        txn(0, "ld_half1",  0, BASE + 32'h1,        32'h0,         SZ_HALF, 0);
        txn(0, "st_w4",     1, BASE + 32'h4,        32'h1234_5678, SZ_WORD, 0);
        txn(0, "st_w6_err", 1, BASE + 32'h6,        32'hFFFF_FFFF, SZ_WORD, 0);
        txn(0, "ld_w4",     0, BASE + 32'h4,        32'h0,         SZ_WORD, 0);
        txn(0, "ld_below",  0, 32'h7FFF_FFFC,       32'h0,         SZ_WORD, 0);
        txn(0, "ld_above",  0, BASE + 32'h1000,     32'h0,         SZ_WORD, 0);
        txn(0, "ld_top",    0, 32'hFFFF_FFFC,       32'h0,         SZ_WORD, 0);
        txn(0, "ld_size3",  0, BASE,                32'h0,         2'd3,    0);
        txn(0, "st_last",   1, BASE + 32'hFFC,      32'hA5A5_0FF0, SZ_WORD, 0);
        txn(0, "st_lasth",  1, BASE + 32'hFFE,      32'h7777_BEAD, SZ_HALF, 0);
        txn(0, "ld_last",   0, BASE + 32'hFFC,      32'h0,         SZ_WORD, 2);

        // LATENCY=4: stalled response, then reset on the would-be commit edge.
        txn(1, "l4_st",     1, BASE + 32'h10,       32'hAABB_CCDD, SZ_WORD, 0);
        txn(1, "l4_ld",     0, BASE + 32'h10,       32'h0,         SZ_WORD, 3);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = BASE + 32'h10;
        req_wdata[1] = 32'h1122_3344;
        req_size[1]  = SZ_WORD;
        tick();
        req_valid[1] = 1'b0;
        tick();
        tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        check_idle_zero(1, "l4_midrst");
        for (int k = 0; k < 6; k++) begin
            tick();
            check("l4_no_resp", 32'(resp_valid[1]), 32'd0);
        end
        txn(1, "l4_after_rst", 0, BASE + 32'h10, 32'h0, SZ_WORD, 0);

        // Randomized back-to-back traffic in a small, fully initialised window.
        for (int u = 0; u < 2; u++) begin
            for (int w = 0; w < 8; w++) begin
                txn(u, "rnd_init", 1, BASE + 32'h200 + 32'(4 * w), $urandom, SZ_WORD, 0);
            end
            for (int i = 0; i < 16; i++) begin
                sz = 2'($urandom_range(0, 2));
                txn(u, "rnd_st", 1, rnd_addr(sz), $urandom, sz, int'($urandom_range(0, 2)));
            end
            for (int i = 0; i < 16; i++) begin
                sz = 2'($urandom_range(0, 2));
                txn(u, "rnd_ld", 0, rnd_addr(sz), 32'h0, sz, int'($urandom_range(0, 2)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
